// File: rtl/demux2to1_tdm_if.sv
// Bus bundle for the two-slot TDM serial demultiplexer.
//   din_valid  : the current cycle carries a beat
//   din_sel    : slot of the beat (0 = channel 0, 1 = channel 1)
//   din        : serial data bit of the beat
//   y0, y1     : last completed word of channel 0 / channel 1
//   y0_valid   : one-cycle strobe when y0 updates
//   y1_valid   : one-cycle strobe when y1 updates
//   sync_err   : one-cycle strobe on a slot-sequence violation
//   locked     : high while the demux is locked to the slot sequence
//   parity_err : one-cycle strobe on a word with bad even parity
//                (only when DEMUX_PARITY_EN is defined)
// Modports: master drives the beats and observes the words; slave is the demux.
interface demux2to1_tdm_if;
  logic       din_valid;
  logic       din_sel;
  logic       din;
  logic [7:0] y0;
  logic       y0_valid;
  logic [7:0] y1;
  logic       y1_valid;
  logic       sync_err;
  logic       locked;
`ifdef DEMUX_PARITY_EN
  logic       parity_err;
`endif

  modport master (
    output din_valid, din_sel, din,
`ifdef DEMUX_PARITY_EN
    input  parity_err,
`endif
    input  y0, y0_valid, y1, y1_valid, sync_err, locked
  );

  modport slave (
    input  din_valid, din_sel, din,
`ifdef DEMUX_PARITY_EN
    output parity_err,
`endif
    output y0, y0_valid, y1, y1_valid, sync_err, locked
  );
endinterface

// File: rtl/demux2to1_tdm.sv
// Two-slot time-division demultiplexer for a serial bit stream.
// Beats alternate between channel 0 and channel 1 (sel 0,1,0,1...). A HUNT/LOCK
// FSM aligns to the first channel-0 beat, then expects the slots to alternate;
// an out-of-order slot drops both partial words, strobes sync_err and re-hunts.
// Each channel assembles its word MSB first and publishes it on y0/y1 with a
// one-cycle valid strobe the cycle after its last beat.
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : demux2to1_tdm_if.slave (din_valid, din_sel, din in; y0, y0_valid,
//         y1, y1_valid, sync_err, locked[, parity_err] out)
// Configuration macro: DEMUX_PARITY_EN -- words become 9 beats (8 data bits
// MSB first, then an even-parity bit) and parity_err is provided.
module demux2to1_tdm (
  input  logic           clk,
  input  logic           rst,
  demux2to1_tdm_if.slave bus
);

  localparam int DATA_W = 8;
`ifdef DEMUX_PARITY_EN
  localparam int WORD_BITS = DATA_W + 1;
`else
  localparam int WORD_BITS = DATA_W;
`endif
  localparam int CNT_W = 4;

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t                 state;
  logic                   exp_sel;
  logic [CNT_W-1:0]       cnt0, cnt1;
  // Only the bits preceding the final beat are stored; the final beat is
  // merged combinationally so the word can be published on that same edge.
  logic [WORD_BITS-2:0]   sh0, sh1;
  logic [DATA_W-1:0]      y0_q, y1_q;
  logic                   y0_valid_q, y1_valid_q;
  logic                   sync_err_q, locked_q;
`ifdef DEMUX_PARITY_EN
  logic                   parity_err_q;
`endif

  logic                   accept, slip;
  logic [WORD_BITS-1:0]   word0, word1;
  logic                   wrap0, wrap1;

  function automatic logic [DATA_W-1:0] word_data(input logic [WORD_BITS-1:0] w);
    return w[WORD_BITS-1 -: DATA_W];
  endfunction

`ifdef DEMUX_PARITY_EN
  // Even parity over data and parity bit: any odd count of ones is an error.
  function automatic logic parity_bad(input logic [WORD_BITS-1:0] w);
    return ^w;
  endfunction
`endif

  // Beat classification: in HUNT only a channel-0 beat is taken (it defines
  // the slot alignment); in LOCK the beat must match the expected slot.
  always_comb begin
    accept = 1'b0;
    slip   = 1'b0;
    if (bus.din_valid) begin
      if (state == HUNT) begin
        accept = !bus.din_sel;
      end else if (bus.din_sel == exp_sel) begin
        accept = 1'b1;
      end else begin
        slip = 1'b1;
      end
    end
  end

  assign word0 = {sh0, bus.din};
  assign word1 = {sh1, bus.din};
  assign wrap0 = accept && !bus.din_sel && (cnt0 == CNT_W'(WORD_BITS - 1));
  assign wrap1 = accept &&  bus.din_sel && (cnt1 == CNT_W'(WORD_BITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HUNT;
      exp_sel      <= 1'b0;
      cnt0         <= '0;
      cnt1         <= '0;
      sh0          <= '0;
      sh1          <= '0;
      y0_q         <= '0;
      y1_q         <= '0;
      y0_valid_q   <= 1'b0;
      y1_valid_q   <= 1'b0;
      sync_err_q   <= 1'b0;
      locked_q     <= 1'b0;
`ifdef DEMUX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      y0_valid_q   <= 1'b0;
      y1_valid_q   <= 1'b0;
      sync_err_q   <= 1'b0;
`ifdef DEMUX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (slip) begin
        // Slot order broken: partial words are meaningless, restart alignment.
        state      <= HUNT;
        locked_q   <= 1'b0;
        exp_sel    <= 1'b0;
        cnt0       <= '0;
        cnt1       <= '0;
        sh0        <= '0;
        sh1        <= '0;
        sync_err_q <= 1'b1;
      end else if (accept) begin
        state    <= LOCK;
        locked_q <= 1'b1;
        exp_sel  <= !bus.din_sel;
        if (!bus.din_sel) begin
          sh0 <= word0[WORD_BITS-2:0];
          if (wrap0) begin
            cnt0       <= '0;
            y0_q       <= word_data(word0);
            y0_valid_q <= 1'b1;
`ifdef DEMUX_PARITY_EN
            parity_err_q <= parity_bad(word0);
`endif
          end else begin
            cnt0 <= cnt0 + CNT_W'(1);
          end
        end else begin
          sh1 <= word1[WORD_BITS-2:0];
          if (wrap1) begin
            cnt1       <= '0;
            y1_q       <= word_data(word1);
            y1_valid_q <= 1'b1;
`ifdef DEMUX_PARITY_EN
            parity_err_q <= parity_bad(word1);
`endif
          end else begin
            cnt1 <= cnt1 + CNT_W'(1);
          end
        end
      end
    end
  end

  assign bus.y0         = y0_q;
  assign bus.y1         = y1_q;
  assign bus.y0_valid   = y0_valid_q;
  assign bus.y1_valid   = y1_valid_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.locked     = locked_q;
`ifdef DEMUX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_demux2to1_tdm.sv
// Self-checking bench for demux2to1_tdm: directed scenarios followed by a
// randomized beat stream, all checked every cycle against a queue-based
// reference model of the slot/word rules.
module tb_demux2to1_tdm;
`ifdef DEMUX_PARITY_EN
  localparam int WB = 9;
`else
  localparam int WB = 8;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux2to1_tdm_if bus();
  demux2to1_tdm dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int v0_cyc = 0;
  int v1_cyc = 0;
  logic perr_at_v0 = 1'b0;

  // Reference model state: lock flag, expected slot, collected bits per channel.
  bit         m_lock, m_exp;
  bit         q0[$], q1[$];
  logic [7:0] m_y0, m_y1;
  bit         m_v0, m_v1, m_serr, m_perr;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int q_value(input bit q[$]);
    int w = 0;
    foreach (q[i]) w = w * 2 + int'(q[i]);
    return w;
  endfunction

  task automatic model(input bit r, input bit v, input bit s, input bit d);
    int w;
    m_v0 = 0; m_v1 = 0; m_serr = 0; m_perr = 0;
    if (r) begin
      m_lock = 0; m_exp = 0; q0.delete(); q1.delete(); m_y0 = 0; m_y1 = 0;
    end else if (v) begin
      if (m_lock && s != m_exp) begin
        m_serr = 1; m_lock = 0; m_exp = 0; q0.delete(); q1.delete();
      end else if (m_lock || s == 0) begin
        m_lock = 1;
        m_exp  = !s;
        if (!s) begin
          q0.push_back(d);
          if (q0.size() == WB) begin
            w = q_value(q0);
            m_y0 = 8'(w >> (WB - 8));
            m_v0 = 1;
            m_perr = (WB == 9) && ($countones(w) % 2 == 1);
            q0.delete();
          end
        end else begin
          q1.push_back(d);
          if (q1.size() == WB) begin
            w = q_value(q1);
            m_y1 = 8'(w >> (WB - 8));
            m_v1 = 1;
            m_perr = (WB == 9) && ($countones(w) % 2 == 1);
            q1.delete();
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("y0", bus.y0, m_y0);
    chk("y1", bus.y1, m_y1);
    chk("y0_valid", {7'd0, bus.y0_valid}, {7'd0, m_v0});
    chk("y1_valid", {7'd0, bus.y1_valid}, {7'd0, m_v1});
    chk("sync_err", {7'd0, bus.sync_err}, {7'd0, m_serr});
    chk("locked", {7'd0, bus.locked}, {7'd0, m_lock});
`ifdef DEMUX_PARITY_EN
    chk("parity_err", {7'd0, bus.parity_err}, {7'd0, m_perr});
    if (bus.y0_valid === 1'b1) perr_at_v0 = bus.parity_err;
`endif
    if (bus.y0_valid === 1'b1) v0_cyc = cyc;
    if (bus.y1_valid === 1'b1) v1_cyc = cyc;
  endtask

  task automatic step(input bit r, input bit v, input bit s, input bit d);
    rst = r; bus.din_valid = v; bus.din_sel = s; bus.din = d;
    @(posedge clk); #1;
    cyc++;
    model(r, v, s, d);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 1'($urandom), 1'($urandom));
  endtask

  task automatic gap(input int gapmax);
    if (gapmax > 0) idle($urandom_range(1, gapmax));
  endtask

  function automatic logic [8:0] mk(input logic [7:0] a);
    return (WB == 9) ? {a, ^a} : {1'b0, a};
  endfunction

  task automatic send_pair(input logic [8:0] a, input logic [8:0] b, input int gapmax);
    for (int i = 0; i < WB; i++) begin
      step(0, 1, 0, a[WB-1-i]);
      gap(gapmax);
      step(0, 1, 1, b[WB-1-i]);
      if (i != WB - 1) gap(gapmax);
    end
  endtask

  initial begin
    rst = 1'b1; bus.din_valid = 1'b0; bus.din_sel = 1'b0; bus.din = 1'b0;
    m_lock = 0; m_exp = 0; m_y0 = 0; m_y1 = 0;
    step(1, 0, 0, 0);
    step(1, 1, 0, 1);
    chk("rst_y0", bus.y0, 8'h00);
    chk("rst_locked", {7'd0, bus.locked}, 8'h00);

    // Basic alternating stream.
    send_pair(mk(8'hA5), mk(8'h3C), 0);
    chk("basic_y0", bus.y0, 8'hA5);
    chk("basic_y1", bus.y1, 8'h3C);
    chk("basic_y1v", {7'd0, bus.y1_valid}, 8'h01);
    chk("basic_locked", {7'd0, bus.locked}, 8'h01);
    chk("basic_order", 8'(v1_cyc - v0_cyc), 8'd1);
    idle(3);
    chk("hold_y0", bus.y0, 8'hA5);

    // Same stream with random idle gaps.
    step(1, 0, 0, 0);
    send_pair(mk(8'hA5), mk(8'h3C), 5);
    chk("gap_y0", bus.y0, 8'hA5);
    chk("gap_y1", bus.y1, 8'h3C);
    chk("gap_order", {7'd0, (v1_cyc > v0_cyc)}, 8'h01);

    // Hunt discards a leading channel-1 beat.
    step(1, 0, 0, 0);
    step(0, 1, 1, 1);
    chk("hunt_sel1_locked", {7'd0, bus.locked}, 8'h00);
    step(0, 1, 0, 1);
    chk("hunt_sel0_locked", {7'd0, bus.locked}, 8'h01);

    // Slot violation: two consecutive channel-0 beats.
    step(0, 1, 1, 0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    chk("slip_sync_err", {7'd0, bus.sync_err}, 8'h01);
    chk("slip_locked", {7'd0, bus.locked}, 8'h00);
    idle(1);
    chk("slip_pulse_end", {7'd0, bus.sync_err}, 8'h00);
    send_pair(mk(8'hFF), mk(8'h00), 0);
    chk("slip_y0", bus.y0, 8'hFF);
    chk("slip_y1", bus.y1, 8'h00);

    // Reset mid-word, with a beat presented in the reset cycle.
    step(0, 1, 0, 1); step(0, 1, 1, 1); step(0, 1, 0, 0);
    step(0, 1, 1, 1); step(0, 1, 0, 1);
    step(1, 1, 1, 1);
    chk("midrst_y0", bus.y0, 8'h00);
    chk("midrst_y1", bus.y1, 8'h00);
    chk("midrst_locked", {7'd0, bus.locked}, 8'h00);
    idle(2);
    chk("midrst_nostrobe", {6'd0, bus.y0_valid, bus.y1_valid}, 8'h00);
    send_pair(mk(8'h5A), mk(8'hC3), 0);
    chk("midrst_y0_after", bus.y0, 8'h5A);
    chk("midrst_y1_after", bus.y1, 8'hC3);

`ifdef DEMUX_PARITY_EN
    send_pair({8'hA5, 1'b1}, mk(8'h3C), 0);
    chk("par_bad_y0", bus.y0, 8'hA5);
    chk("par_bad_err", {7'd0, perr_at_v0}, 8'h01);
    send_pair({8'hA5, 1'b0}, mk(8'h3C), 0);
    chk("par_good_err", {7'd0, perr_at_v0}, 8'h00);
`endif

    // Random stream: mostly well-formed, with occasional slips and resets.
    for (int n = 0; n < 600; n++) begin
      bit r, v, s, d;
      r = ($urandom_range(0, 99) < 2);
      v = ($urandom_range(0, 99) < 75);
      s = ($urandom_range(0, 99) < 90) ? m_exp : !m_exp;
      d = 1'($urandom);
      step(r, v, s, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/demux2to1_tdm.md
DEMUX2TO1_TDM -- requirements
Module: demux2to1_tdm

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous active-high reset, sampled on the clk rising edge.
REQ-003 SHALL have port din_valid, input, 1 bit: the current cycle carries a beat.
REQ-004 SHALL have port din_sel, input, 1 bit: slot select of the beat (0 = channel 0, 1 = channel 1).
REQ-005 SHALL have port din, input, 1 bit: serial data bit of the beat.
REQ-006 SHALL have port y0, output, 8 bits: last completed channel-0 word.
REQ-007 SHALL have port y0_valid, output, 1 bit: one-cycle strobe when y0 updates.
REQ-008 SHALL have port y1, output, 8 bits: last completed channel-1 word.
REQ-009 SHALL have port y1_valid, output, 1 bit: one-cycle strobe when y1 updates.
REQ-010 SHALL have port sync_err, output, 1 bit: one-cycle strobe on slot-sequence violation.
REQ-011 SHALL have port locked, output, 1 bit: high while in state LOCK.
REQ-012 SHALL have port parity_err, output, 1 bit, present only with DEMUX_PARITY_EN: one-cycle strobe on a bad word.

Function
REQ-013 SHALL implement a two-state FSM, HUNT and LOCK, together with an expected-slot register exp_sel.
REQ-014 In HUNT, a beat with din_sel=0 SHALL be accepted as a channel-0 bit, set exp_sel=1 and enter LOCK; a beat with din_sel=1 SHALL be discarded.
REQ-015 In LOCK, a beat with din_sel==exp_sel SHALL be accepted and SHALL toggle exp_sel.
REQ-016 In LOCK, a beat with din_sel!=exp_sel SHALL be discarded, pulse sync_err the next cycle, clear both bit counters and shift registers, and return to HUNT.
REQ-017 Cycles with din_valid=0 SHALL change no state; gaps of any length are legal.
REQ-018 Each channel SHALL own a shift register, MSB first, and a bit counter that wraps modulo WORD_BITS (8, or 9 with parity).
REQ-019 An accepted beat SHALL shift din into the selected channel only; the other channel is untouched.
REQ-020 When a channel's bit counter wraps, its word SHALL be copied to y0/y1 and y0_valid/y1_valid SHALL pulse high for exactly 1 cycle, with a latency of one cycle after the last beat.
REQ-021 y0/y1 SHALL hold their value until the next completed word.
REQ-022 y0_valid and y1_valid SHALL never be high in the same cycle, because only one beat is accepted per cycle.

Reset
REQ-023 rst SHALL have priority over din_valid in the same cycle.
REQ-024 On reset: FSM=HUNT, exp_sel=0, counters=0, shift registers=0, and y0, y1, y0_valid, y1_valid, sync_err, locked and parity_err all 0.
REQ-025 Reset asserted mid-word SHALL discard the partial words; no strobe SHALL be issued.

Configuration
REQ-026 Macro DEMUX_PARITY_EN SHALL gate the parity feature.
REQ-027 With DEMUX_PARITY_EN defined: words are 9 beats (8 data bits MSB first, then an even-parity bit); port parity_err exists.
REQ-028 With DEMUX_PARITY_EN defined, a parity mismatch SHALL pulse parity_err with the word strobe, and y still updates.
REQ-029 Without DEMUX_PARITY_EN: words are 8 beats, there is no parity_err port, and no parity logic exists.

Verification
REQ-030 Reset, then 16 alternating beats (sel 0,1,0,1...) carrying channel-0 0xA5 and channel-1 0x3C -> y0=0xA5 and y1=0x3C; y0_valid pulses before y1_valid, 1 cycle apart; locked=1.
REQ-031 After reset, first beat sel=1 -> discarded, locked stays 0; the next sel=0 beat -> locked=1.
REQ-032 In LOCK, two consecutive sel=0 beats -> sync_err 1-cycle pulse, locked=0, partial words lost; a fresh 0xFF/0x00 stream then decodes correctly.
REQ-033 The REQ-030 stream with random din_valid=0 gaps (1-5 cycles) -> identical outputs and strobes.
REQ-034 rst high after 5 accepted beats -> all outputs 0 and no strobes; a full stream afterwards decodes correctly.
REQ-035 With DEMUX_PARITY_EN: channel-0 word 0xA5 with parity bit 1 -> y0=0xA5, y0_valid=1 and parity_err=1 in the same cycle; with parity bit 0 -> parity_err=0.
